// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encoding, default latencies
// and op-class helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit products and
// truncating division, result packed as {hi, lo}.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        dbz_o
);

  logic        sgn;
  logic [63:0] ea;
  logic [63:0] eb;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] q;
  logic [31:0] r;

  always_comb begin
    sgn   = is_signed_op(op_i);
    ea    = sgn ? {{32{a_i[31]}}, a_i} : {32'b0, a_i};
    eb    = sgn ? {{32{b_i[31]}}, b_i} : {32'b0, b_i};
    // Divide magnitudes, then fix signs; INT_MIN/-1 falls out as INT_MIN.
    ua    = (sgn && a_i[31]) ? -a_i : a_i;
    ub    = (sgn && b_i[31]) ? -b_i : b_i;
    dbz_o = is_div(op_i) && (b_i == 32'd0);
    q     = (b_i == 32'd0) ? 32'd0 : ua / ub;
    r     = (b_i == 32'd0) ? 32'd0 : ua % ub;
    if (sgn && (a_i[31] ^ b_i[31])) q = -q;
    if (sgn && a_i[31]) r = -r;
    res_o = '0;
    unique case (1'b1)
      is_mul(op_i): res_o = ea * eb;
      is_div(op_i): res_o = {r, q};
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: HI/LO registers, busy counter
// emulating multi-cycle latency, commit at end of window.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAXC + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   res_q, res_d;
  logic          wr_q, wr_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0]   ar_res;
  logic          ar_dbz;

  mdu_arith u_arith (
    .op_i  (op),
    .a_i   (rs_val),
    .b_i   (rt_val),
    .res_o (ar_res),
    .dbz_o (ar_dbz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul(op): begin
              state_d = BUSY;
              cnt_d   = CW'(MULT_CYCLES - 1);
              res_d   = ar_res;
              wr_d    = 1'b1;
            end
            is_div(op): begin
              state_d = BUSY;
              cnt_d   = CW'(DIV_CYCLES - 1);
              res_d   = ar_res;
              wr_d    = !ar_dbz;
            end
            op == MDU_MTHI: hi_d = rs_val;
            op == MDU_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        // Starts arriving here are dropped by design.
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (wr_q) {hi_d, lo_d} = res_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: latencies, signed/unsigned
// results, divide corner cases, moves and async reset.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  int n;

  mdu dut (
    .clk    (clk),
    .reset  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepted at the posedge between the two negedges.
  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0;
    rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_pre_hi", hi, 32'd0);
    check("mult_pre_lo", lo, 32'd0);
    wait_idle(n);
    check("mult_lat", n, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    check("multu_pre_hi", hi, 32'hFFFF_FFFF);
    wait_idle(n);
    check("multu_lat", n, 32'd5);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_lat", n, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    issue(MDU_MTHI, 32'h11, 32'd0);
    issue(MDU_MTLO, 32'h22, 32'd0);
    issue(MDU_DIVU, 32'd9, 32'd0);
    wait_idle(n);
    check("dbz_lat", n, 32'd10);
    check("dbz_hi", hi, 32'h11);
    check("dbz_lo", lo, 32'h22);

    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo", lo, 32'h22);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    op = MDU_MTLO; rs_val = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_hi", hi, 32'hDEAD_BEEF);
    check("mtlo_busy", {31'b0, busy}, 32'd0);

    issue(MDU_MULT, 32'd6, 32'd7);
    start = 1'b1; op = MDU_MTLO; rs_val = 32'h5;
    @(negedge clk);
    start = 1'b0;
    check("ign_lo_mid", lo, 32'h1234_5678);
    wait_idle(n);
    check("ign_lat", n + 1, 32'd5);
    check("ign_lo", lo, 32'd42);
    check("ign_hi", hi, 32'd0);

    issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("unused_busy", {31'b0, busy}, 32'd0);
    check("unused_lo", lo, 32'd42);
    check("unused_hi", hi, 32'd0);

    issue(MDU_MTHI, 32'h77, 32'd0);
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("mid_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_nocommit_lo", lo, 32'd0);
    check("arst_nocommit_hi", hi, 32'd0);
    check("arst_idle", {31'b0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit for the pipelined MIPS core, in the EX stage beside the ALU.
- Consumes the forwarded rs/rt operands of MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers.
- Emulates hardware latency with a busy counter so the hazard unit can stall dependent MFHI/MFLO/MD instructions in D.

Parameters:
- MULT_CYCLES, 5, cycles busy is held after a multiply start (≥1)
- DIV_CYCLES, 10, cycles busy is held after a divide start (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  EX-stage instruction is an MDU op; qualifies op
- op  in  3  MDU operation code (see Decomposition)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  multi-cycle operation in progress
- hi  out  32  current HI register
- lo  out  32  current LO register

Behaviour:
- Reset (reset=0, any time, including mid-operation): hi=0, lo=0, busy=0, counter=0, pending result discarded; takes effect immediately, not at clock edge.
- Accept condition: start=1 && busy=0 at a rising edge. start while busy=1 is ignored (hazard unit guarantees no such issue; MDU must not corrupt state if it happens).
- MULT/MULTU accepted at edge T:
  - product computed from captured rs_val, rt_val (signed/unsigned 64-bit);
  - busy=1 from T through end of cycle T+MULT_CYCLES-1;
  - hi/lo update at edge T+MULT_CYCLES, same edge busy falls to 0;
  - hi=product[63:32], lo=product[31:0].
- DIV/DIVU accepted at edge T: same as multiply but with DIV_CYCLES; lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes sign of dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) -> lo=0x80000000, hi=0.
  - Divisor=0 (either variant): operation still occupies DIV_CYCLES of busy; hi/lo left unchanged.
- MTHI/MTLO accepted at edge T: hi (resp. lo) <= rs_val at T; busy stays 0; the other register unchanged.
- hi/lo outputs are registered and show the pre-operation values throughout the busy window.
- Unused op codes with start=1: no state change.
- Counter: loaded with latency-1 on accept, decremented while busy, result committed when it reaches 0 and busy=1. No wrap.
- Hazard unit stalls D when (busy || start) && D holds an MDU-class instruction. That logic lives outside this block.
- Back-to-back: a new op may be accepted at the same edge busy falls? No. The first possible accept is the edge after busy is observed 0.

Decomposition:
- Shared package mdu_pkg:
  - op encoding: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5;
  - default latency constants.
- One natural sub-module: mdu_arith, purely combinational.
  - Inputs: op, operand pair. Outputs: 64-bit {hi,lo} result and div_by_zero flag.
  - Top level keeps the FSM (IDLE/BUSY), counter and HI/LO.

Test Plan:
- Reset 0 for 3 cycles, release -> hi=0, lo=0, busy=0. Assert reset mid-DIV (cycle 4 of busy) -> busy, hi, lo drop to 0 immediately.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU rt=0 with hi/lo preloaded 0x11/0x22 -> busy 10 cycles, hi=0x11, lo=0x22 after.
- MTHI rs=0xDEADBEEF then MTLO rs=0x12345678 on consecutive cycles -> hi/lo updated one edge each, busy never asserts.
- MULT in progress, pulse start with MTLO rs=0x5 at cycle 2 -> ignored; final lo = product low word, not 5.
